// File: rtl/nios2_debug_ocimem_sequencer.sv
// Debug-host command sequencer for the Nios II OCI memory: set-address / write / read / clear-error,
// with a per-access waitrequest timeout. Define NIOS2_DEBUG_OCIMEM_AUTOINC_EN for address auto-increment.
module nios2_debug_ocimem_sequencer #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       mon_dreg,
  output logic              mon_ready,
  output logic              mon_error
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  localparam logic [1:0]  OpSetAddr  = 2'b00;
  localparam logic [1:0]  OpWrite    = 2'b01;
  localparam logic [1:0]  OpRead     = 2'b10;
  localparam logic [1:0]  OpClrErr   = 2'b11;
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       dreg_q, dreg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic [15:0]       tcnt_q, tcnt_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dreg_d  = dreg_q;
    ready_d = ready_q;
    error_d = error_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          tcnt_d = '0;
          unique case (cmd_op)
            OpSetAddr: addr_d = cmd_data[ADDR_W-1:0];
            OpWrite: begin
              wdata_d = cmd_data;
              state_d = StWrite;
              ready_d = 1'b0;
            end
            OpRead: begin
              state_d = StRead;
              ready_d = 1'b0;
            end
            OpClrErr: error_d = 1'b0;
          endcase
        end
      end
      StWrite, StRead: begin
        if (!mem_waitrequest) begin
          state_d = StIdle;
          ready_d = 1'b1;
          if (state_q == StRead) begin
            dreg_d = mem_readdata;
          end
`ifdef NIOS2_DEBUG_OCIMEM_AUTOINC_EN
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif
        end else begin
          tcnt_d = tcnt_q + 16'd1;
          // This stalled cycle brings the count to TIMEOUT: abandon the access.
          if (tcnt_q == TimeoutVal - 16'd1) begin
            state_d = StIdle;
            ready_d = 1'b1;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      dreg_q  <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dreg_q  <= dreg_d;
      ready_q <= ready_d;
      error_q <= error_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign mem_write     = (state_q == StWrite);
  assign mem_read      = (state_q == StRead);
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign mon_dreg      = dreg_q;
  assign mon_ready     = ready_q;
  assign mon_error     = error_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_sequencer.sv
// Bench for nios2_debug_ocimem_sequencer: dut_a uses the default TIMEOUT, dut_b TIMEOUT=4 for the
// timeout cases; both share inputs and a queue-based access scoreboard watches the selected one.
module tb_nios2_debug_ocimem_sequencer;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [31:0]   cmd_data = '0;
  logic [31:0]   mem_readdata = '0;
  logic          mem_waitrequest = 1'b0;

  logic          a_cmd_ready, a_rd, a_wr, a_ready, a_err;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata, a_dreg;
  logic          b_cmd_ready, b_rd, b_wr, b_ready, b_err;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata, b_dreg;

  nios2_debug_ocimem_sequencer #(.ADDR_W(AW), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .mem_address(a_addr), .mem_read(a_rd), .mem_write(a_wr),
    .mem_writedata(a_wdata), .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .mon_dreg(a_dreg), .mon_ready(a_ready), .mon_error(a_err)
  );

  nios2_debug_ocimem_sequencer #(.ADDR_W(AW), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .mem_address(b_addr), .mem_read(b_rd), .mem_write(b_wr),
    .mem_writedata(b_wdata), .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .mon_dreg(b_dreg), .mon_ready(b_ready), .mon_error(b_err)
  );

  logic          sel_b = 1'b0;
  logic          s_cmd_ready, s_rd, s_wr, s_ready, s_err;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata, s_dreg;
  assign s_cmd_ready = sel_b ? b_cmd_ready : a_cmd_ready;
  assign s_rd        = sel_b ? b_rd : a_rd;
  assign s_wr        = sel_b ? b_wr : a_wr;
  assign s_ready     = sel_b ? b_ready : a_ready;
  assign s_err       = sel_b ? b_err : a_err;
  assign s_addr      = sel_b ? b_addr : a_addr;
  assign s_wdata     = sel_b ? b_wdata : a_wdata;
  assign s_dreg      = sel_b ? b_dreg : a_dreg;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } acc_t;

  acc_t          exp_q[$];
  logic          mon_en = 1'b0;
  logic          rd_chk = 1'b0;
  logic [31:0]   rd_exp = '0;
  logic [AW-1:0] model_addr = '0;

  // Access monitor: every strobe cycle must match the queue head; completion pops it.
  always @(negedge clk) begin
    #1;
    if (rd_chk) begin
      chk("sb_dreg", s_dreg, rd_exp);
      rd_chk = 1'b0;
    end
    if (mon_en && (s_rd || s_wr)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_access: got rd=%b wr=%b addr=%h expected no access",
                 s_rd, s_wr, s_addr);
      end else begin
        chk("sb_we", {31'd0, s_wr}, {31'd0, exp_q[0].we});
        chk("sb_addr", {23'd0, s_addr}, {23'd0, exp_q[0].addr});
        if (exp_q[0].we) chk("sb_wdata", s_wdata, exp_q[0].data);
        if (!mem_waitrequest) begin
          if (!exp_q[0].we) begin
            rd_chk = 1'b1;
            rd_exp = exp_q[0].data;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at a negedge with the selected DUT idle; returns the number of strobe cycles seen.
  task automatic issue(input logic [1:0] op, input logic [31:0] d, input int stalls,
                       input logic [31:0] rdata, input bit push, input bit noise, output int n);
    int rem;
    chk("cmd_ready_idle", {31'd0, s_cmd_ready}, 32'd1);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_data     = d;
    mem_readdata = rdata;
    if (op == 2'b00) model_addr = d[AW-1:0];
    if (push && (op == 2'b01 || op == 2'b10))
      exp_q.push_back('{we: (op == 2'b01), addr: model_addr, data: (op == 2'b01) ? d : rdata});
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    rem = stalls;
    while ((s_rd || s_wr) && n < 100) begin
      n++;
      chk("cmd_ready_busy", {31'd0, s_cmd_ready}, 32'd0);
      chk("mon_ready_busy", {31'd0, s_ready}, 32'd0);
      mem_waitrequest = (rem > 0);
      if (rem > 0) rem--;
      if (noise) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 32'h0000_0077;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    mem_waitrequest = 1'b0;
    chk("strobe_bound", {31'd0, n < 100}, 32'd1);
`ifdef NIOS2_DEBUG_OCIMEM_AUTOINC_EN
    if (push && (op == 2'b01 || op == 2'b10)) model_addr = model_addr + 1'b1;
`endif
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          stalls;
    logic [31:0] rdata;
    bit          noise;
    int          exp_n;
    logic [31:0] exp_dreg;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    vecs[0] = '{2'b00, 32'h0000_0010, 0, 32'h0, 1'b0, 0, 32'h0};
    vecs[1] = '{2'b01, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1, 32'h0};
    vecs[2] = '{2'b10, 32'h0, 5, 32'h1234_5678, 1'b0, 6, 32'h1234_5678};
    vecs[3] = '{2'b00, 32'h0000_01FF, 0, 32'h0, 1'b0, 0, 32'h1234_5678};
    vecs[4] = '{2'b10, 32'h0, 0, 32'hA5A5_A5A5, 1'b0, 1, 32'hA5A5_A5A5};
    vecs[5] = '{2'b10, 32'h0, 0, 32'h5A5A_0001, 1'b0, 1, 32'h5A5A_0001};
    vecs[6] = '{2'b01, 32'hCAFE_0000, 3, 32'h0, 1'b1, 4, 32'h5A5A_0001};
    vecs[7] = '{2'b11, 32'h0, 0, 32'h0, 1'b0, 0, 32'h5A5A_0001};
    vecs[8] = '{2'b00, 32'hFFFF_F2BC, 0, 32'h0, 1'b0, 0, 32'h5A5A_0001};
    vecs[9] = '{2'b10, 32'h0, 2, 32'h0BAD_F00D, 1'b1, 3, 32'h0BAD_F00D};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, a_cmd_ready}, 32'd1);
    chk("rst_strobes", {30'd0, a_rd, a_wr}, 32'd0);
    chk("rst_addr", {23'd0, a_addr}, 32'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_dreg", a_dreg, 32'd0);
    chk("rst_flags", {30'd0, a_ready, a_err}, 32'd2);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].data, vecs[i].stalls, vecs[i].rdata, 1'b1, vecs[i].noise, n);
      chk($sformatf("v%0d_cycles", i), n, vecs[i].exp_n);
      chk($sformatf("v%0d_dreg", i), a_dreg, vecs[i].exp_dreg);
      chk($sformatf("v%0d_addr", i), {23'd0, a_addr}, {23'd0, model_addr});
      chk($sformatf("v%0d_idle", i), {28'd0, a_cmd_ready, a_ready, a_rd, a_wr}, 32'hC);
      chk($sformatf("v%0d_err", i), {31'd0, a_err}, 32'd0);
    end

    // Reset on the second stall cycle of a write
    mon_en    = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 32'h1357_9BDF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rw_strobe1", {31'd0, a_wr}, 32'd1);
    mem_waitrequest = 1'b1;
    @(negedge clk);
    chk("rw_strobe2", {31'd0, a_wr}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    chk("rw_strobes", {30'd0, a_rd, a_wr}, 32'd0);
    chk("rw_addr", {23'd0, a_addr}, 32'd0);
    chk("rw_wdata", a_wdata, 32'd0);
    chk("rw_dreg", a_dreg, 32'd0);
    chk("rw_flags", {29'd0, a_cmd_ready, a_ready, a_err}, 32'd6);
    model_addr = '0;
    mon_en = 1'b1;
    issue(2'b10, 32'h0, 0, 32'h2468_ACE0, 1'b1, 1'b0, n);
    chk("post_rst_cycles", n, 1);
    chk("post_rst_dreg", a_dreg, 32'h2468_ACE0);

    // Timeout cases on the TIMEOUT=4 instance
    sel_b = 1'b1;
    issue(2'b10, 32'h0, 3, 32'h1111_2222, 1'b1, 1'b0, n);
    chk("to_edge_cycles", n, 4);
    chk("to_edge_dreg", b_dreg, 32'h1111_2222);
    chk("to_edge_err", {31'd0, b_err}, 32'd0);
    mon_en = 1'b0;
    issue(2'b10, 32'h0, 50, 32'hFFFF_0000, 1'b0, 1'b0, n);
    mon_en = 1'b1;
    chk("to_cycles", n, 4);
    chk("to_err", {31'd0, b_err}, 32'd1);
    chk("to_dreg", b_dreg, 32'h1111_2222);
    chk("to_ready", {30'd0, b_cmd_ready, b_ready}, 32'd3);
    issue(2'b10, 32'h0, 0, 32'h3333_4444, 1'b1, 1'b0, n);
    chk("sticky_cycles", n, 1);
    chk("sticky_dreg", b_dreg, 32'h3333_4444);
    chk("sticky_err", {31'd0, b_err}, 32'd1);
    issue(2'b11, 32'h0, 0, 32'h0, 1'b1, 1'b0, n);
    chk("clr_err", {31'd0, b_err}, 32'd0);

    @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
